// File: rtl/sq_pkg.sv
// Shared definitions for the store commit queue: access-size encoding,
// strobe width derivation, byte-strobe mask and lane-shift helpers.
// Helpers work at the widest supported word (64 bits); callers truncate
// to their own DATA_WIDTH / STRB_WIDTH.
package sq_pkg;

    // Store / load access size as carried on enq_size and lookup_size.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

    // Byte strobes per memory word.
    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    // Number of bytes touched by an access of the given size.
    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    // Byte-enable mask of an access, positioned at its byte offset.
    function automatic logic [MAX_STRB_WIDTH-1:0] strb_mask(input logic [1:0] size,
                                                            input logic [2:0] offset);
        logic [MAX_STRB_WIDTH-1:0] base;
        case (size_e'(size))
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    // Keep only the bytes the access writes, then move them to their lanes.
    function automatic logic [MAX_DATA_WIDTH-1:0] lane_shift(input logic [MAX_DATA_WIDTH-1:0] data,
                                                             input logic [1:0] size,
                                                             input logic [2:0] offset);
        logic [MAX_DATA_WIDTH-1:0] masked;
        case (size_e'(size))
            SZ_B:    masked = {56'd0, data[7:0]};
            SZ_H:    masked = {48'd0, data[15:0]};
            SZ_W:    masked = {32'd0, data[31:0]};
            default: masked = data;
        endcase
        return masked << {offset, 3'b000};
    endfunction

endpackage

// File: rtl/sq_fwd_merge.sv
// Per-byte youngest-match selection for store-to-load forwarding.
// Walks the ring from the oldest slot (head) to the youngest, so the
// last matching store written into each byte lane is the youngest one.
// Only instantiated when STORE_COMMIT_QUEUE_FWD_EN is defined.
module sq_fwd_merge
    import sq_pkg::*;
#(
    parameter  int ENTRIES    = 8,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = strb_width(DATA_WIDTH),
    localparam int PTR_W      = $clog2(ENTRIES)
) (
    input  logic [PTR_W-1:0]      head_slot,
    input  logic [ENTRIES-1:0]    match,
    input  logic [STRB_WIDTH-1:0] strb [ENTRIES],
    input  logic [DATA_WIDTH-1:0] data [ENTRIES],
    output logic [STRB_WIDTH-1:0] cov,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [PTR_W-1:0] idx;

    // Oldest-to-youngest scan; younger matches overwrite older ones per byte.
    always_comb begin
        cov      = '0;
        data_out = '0;
        idx      = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            idx = head_slot + PTR_W'(k);
            if (match[idx]) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (strb[idx][b]) begin
                        cov[b]           = 1'b1;
                        data_out[b*8 +: 8] = data[idx][b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_commit_queue.sv
// Store commit queue: a ring of ENTRIES stores split by three pointers.
// [head, cmt) are committed stores waiting to drain to memory,
// [cmt, tail) are speculative stores that a flush discards.
// Pointers carry one extra wrap bit so full/empty/count fall out of a
// subtraction. Loads probe the queue combinationally for forwarding.
// Optional feature macro: STORE_COMMIT_QUEUE_FWD_EN (byte forwarding);
// without it the probe only reports overlap so the load can stall.
//
// Handshakes: enq fires on enq_valid && enq_ready (enq_ready = !full);
// a drain write completes on mem_wr_valid && mem_wr_ready, and the head
// outputs stay stable while mem_wr_valid is high and ready is low.
module store_commit_queue
    import sq_pkg::*;
#(
    parameter  int ENTRIES    = 8,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = strb_width(DATA_WIDTH),
    localparam int PTR_W      = $clog2(ENTRIES),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // allocate
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [ADDR_WIDTH-1:0] enq_addr,
    input  logic [DATA_WIDTH-1:0] enq_data,
    input  logic [1:0]            enq_size,
    output logic [PTR_W-1:0]      enq_sq_id,
    output logic                  enq_err,
    // retire / squash
    input  logic                  commit_valid,
    input  logic                  flush,
    // drain
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [STRB_WIDTH-1:0] mem_wr_strb,
    // load probe
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    input  logic [1:0]            lookup_size,
    output logic                  fwd_hit,
    output logic                  fwd_partial,
    output logic [DATA_WIDTH-1:0] fwd_data,
    // status
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    localparam int OFF_W   = $clog2(STRB_WIDTH);
    localparam int WADDR_W = ADDR_WIDTH - OFF_W;

    // Pointer and pulse state.
    logic [CNT_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] cmt_q,  cmt_d;
    logic [CNT_W-1:0] tail_q, tail_d;
    logic             enq_err_q, enq_err_d;

    // Entry payload (word address, lane-positioned data, byte strobes).
    logic [WADDR_W-1:0]    waddr_q [ENTRIES];
    logic [WADDR_W-1:0]    waddr_d [ENTRIES];
    logic [DATA_WIDTH-1:0] data_q  [ENTRIES];
    logic [DATA_WIDTH-1:0] data_d  [ENTRIES];
    logic [STRB_WIDTH-1:0] strb_q  [ENTRIES];
    logic [STRB_WIDTH-1:0] strb_d  [ENTRIES];

    logic [PTR_W-1:0]      head_slot, tail_slot;
    logic [2:0]            enq_off, lk_off;
    logic [STRB_WIDTH-1:0] enq_strb, lk_req;
    logic [DATA_WIDTH-1:0] enq_lanes;
    logic                  enq_legal;
    logic                  has_spec, pop, commit, enq_hs, enq_fire;
    logic [ENTRIES-1:0]    entry_valid, match;
    logic [PTR_W-1:0]      age;

    assign head_slot = head_q[PTR_W-1:0];
    assign tail_slot = tail_q[PTR_W-1:0];

    // Decode the incoming store: lane placement, strobes and legality.
    // An access is legal only if it stays inside one memory word, which
    // also rejects doublewords on a 32-bit word.
    always_comb begin
        enq_off   = 3'(enq_addr[OFF_W-1:0]);
        enq_strb  = STRB_WIDTH'(strb_mask(enq_size, enq_off));
        enq_lanes = DATA_WIDTH'(lane_shift(64'(enq_data), enq_size, enq_off));
        enq_legal = (int'(enq_off) + size_bytes(enq_size)) <= STRB_WIDTH;
    end

    // Occupancy, handshakes and next pointer values.
    always_comb begin
        count        = tail_q - head_q;
        full         = (count == CNT_W'(ENTRIES));
        empty        = (count == '0);
        enq_ready    = !full;
        mem_wr_valid = (head_q != cmt_q);
        has_spec     = (cmt_q != tail_q);
        pop          = mem_wr_valid && mem_wr_ready;
        // Uses the pre-edge tail, so a store enqueued this cycle cannot
        // be committed in the same cycle.
        commit       = commit_valid && has_spec;
        enq_hs       = enq_valid && enq_ready && !flush;
        enq_fire     = enq_hs && enq_legal;
        enq_err_d    = enq_hs && !enq_legal;
        head_d       = head_q + CNT_W'(pop);
        cmt_d        = cmt_q + CNT_W'(commit);
        // Flush rolls tail back to the commit point after this cycle's commit.
        tail_d       = flush ? cmt_d : (tail_q + CNT_W'(enq_fire));
    end

    // Pointer registers; reset drops every entry, including one mid-drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            cmt_q     <= '0;
            tail_q    <= '0;
            enq_err_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            cmt_q     <= cmt_d;
            tail_q    <= tail_d;
            enq_err_q <= enq_err_d;
        end
    end

    // Write the tail slot when a legal store is accepted.
    always_comb begin
        waddr_d = waddr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        if (enq_fire) begin
            waddr_d[tail_slot] = enq_addr[ADDR_WIDTH-1:OFF_W];
            data_d[tail_slot]  = enq_lanes;
            strb_d[tail_slot]  = enq_strb;
        end
    end

    // Payload storage; validity lives entirely in the pointers.
    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        data_q  <= data_d;
        strb_q  <= strb_d;
    end

    assign enq_sq_id   = tail_slot;
    assign enq_err     = enq_err_q;
    assign mem_wr_addr = {waddr_q[head_slot], OFF_W'(0)};
    assign mem_wr_data = data_q[head_slot];
    assign mem_wr_strb = strb_q[head_slot];

    // Probe decode: requested bytes and per-entry word-address match.
    // A slot is live when its distance from head is below count.
    always_comb begin
        lk_off      = 3'(lookup_addr[OFF_W-1:0]);
        lk_req      = STRB_WIDTH'(strb_mask(lookup_size, lk_off));
        entry_valid = '0;
        match       = '0;
        age         = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            age            = PTR_W'(i) - head_slot;
            entry_valid[i] = ({1'b0, age} < count);
            match[i]       = entry_valid[i] &&
                             (waddr_q[i] == lookup_addr[ADDR_WIDTH-1:OFF_W]);
        end
    end

`ifdef STORE_COMMIT_QUEUE_FWD_EN
    logic [STRB_WIDTH-1:0] cov, got;
    logic [DATA_WIDTH-1:0] merged;

    sq_fwd_merge #(
        .ENTRIES    (ENTRIES),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fwd_merge (
        .head_slot (head_slot),
        .match     (match),
        .strb      (strb_q),
        .data      (data_q),
        .cov       (cov),
        .data_out  (merged)
    );

    // Classify coverage of the requested bytes and zero uncovered lanes.
    always_comb begin
        fwd_hit     = 1'b0;
        fwd_partial = 1'b0;
        fwd_data    = '0;
        got         = cov & lk_req;
        if (lookup_valid) begin
            fwd_hit     = (lk_req != '0) && (got == lk_req);
            fwd_partial = (got != '0) && (got != lk_req);
            for (int b = 0; b < STRB_WIDTH; b++) begin
                fwd_data[b*8 +: 8] = got[b] ? merged[b*8 +: 8] : 8'h00;
            end
        end
    end
`else
    logic overlap;

    // No forwarding: any byte overlap with a queued store stalls the load.
    always_comb begin
        overlap = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (match[i] && ((strb_q[i] & lk_req) != '0)) begin
                overlap = 1'b1;
            end
        end
        fwd_hit     = 1'b0;
        fwd_data    = '0;
        fwd_partial = lookup_valid && overlap;
    end
`endif

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed bench for store_commit_queue (default parameters).
// A queue-based model predicts every output; a negedge compare process
// checks it each cycle, and literal expectations pin key scenarios.
module tb_store_commit_queue;

    localparam int E  = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enq_valid = 1'b0;
    logic          enq_ready;
    logic [AW-1:0] enq_addr = '0;
    logic [DW-1:0] enq_data = '0;
    logic [1:0]    enq_size = '0;
    logic [2:0]    enq_sq_id;
    logic          enq_err;
    logic          commit_valid = 1'b0;
    logic          flush = 1'b0;
    logic          mem_wr_valid;
    logic          mem_wr_ready = 1'b0;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic [SB-1:0] mem_wr_strb;
    logic          lookup_valid = 1'b0;
    logic [AW-1:0] lookup_addr = '0;
    logic [1:0]    lookup_size = '0;
    logic          fwd_hit;
    logic          fwd_partial;
    logic [DW-1:0] fwd_data;
    logic          full;
    logic          empty;
    logic [3:0]    count;

    store_commit_queue #(.ENTRIES(E), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_addr     (enq_addr),
        .enq_data     (enq_data),
        .enq_size     (enq_size),
        .enq_sq_id    (enq_sq_id),
        .enq_err      (enq_err),
        .commit_valid (commit_valid),
        .flush        (flush),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_strb  (mem_wr_strb),
        .lookup_valid (lookup_valid),
        .lookup_addr  (lookup_addr),
        .lookup_size  (lookup_size),
        .fwd_hit      (fwd_hit),
        .fwd_partial  (fwd_partial),
        .fwd_data     (fwd_data),
        .full         (full),
        .empty        (empty),
        .count        (count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int n_drained = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    ent_t mq[$];      // oldest at front
    int   m_cmt  = 0; // committed entries at the front of mq
    int   m_tail = 0; // slot the next store gets
    bit   m_err  = 0;

    // Build the memory image of a store; returns 0 if it crosses a word.
    function automatic bit make_entry(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] sz, output ent_t e);
        int off;
        int nb;
        logic [63:0] dm;
        off = int'(a[1:0]);
        nb  = 1 << sz;
        dm  = (nb >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        e.addr = {a[31:2], 2'b00};
        e.strb = 4'(((1 << nb) - 1) << off);
        e.data = 32'(({32'd0, d} & dm) << (8 * off));
        return (off + nb) <= SB;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Youngest-first search per requested byte.
    function automatic void model_fwd(input logic [31:0] la, input logic [1:0] ls,
                                      output bit hit, output bit part, output logic [31:0] d);
        int off;
        int nb;
        logic [3:0] req;
        logic [3:0] cov;
        off = int'(la[1:0]);
        nb  = 1 << ls;
        cov = '0;
        d   = '0;
        for (int b = 0; b < 4; b++) req[b] = (b >= off) && (b < off + nb);
        for (int b = 0; b < 4; b++) begin
            if (req[b]) begin
                for (int j = mq.size() - 1; j >= 0; j--) begin
                    if (mq[j].addr == {la[31:2], 2'b00} && mq[j].strb[b]) begin
                        cov[b] = 1'b1;
                        d[b*8 +: 8] = mq[j].data[b*8 +: 8];
                        break;
                    end
                end
            end
        end
`ifdef STORE_COMMIT_QUEUE_FWD_EN
        hit  = (req != 0) && (cov == req);
        part = (cov != 0) && (cov != req);
`else
        hit  = 1'b0;
        part = (cov != 0);
        d    = '0;
`endif
    endfunction

    // Model state advances on each clock edge and on asynchronous reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_cmt  = 0;
                m_tail = 0;
                m_err  = 0;
            end else begin
                bit   do_pop;
                bit   do_commit;
                bit   room;
                bit   ok;
                ent_t e;
                do_pop    = (m_cmt > 0) && mem_wr_ready;
                do_commit = commit_valid && (mq.size() > m_cmt);
                room      = mq.size() < E;
                ok        = make_entry(enq_addr, enq_data, enq_size, e);
                m_err     = 0;
                if (do_pop) begin
                    void'(mq.pop_front());
                    m_cmt--;
                end
                if (do_commit) m_cmt++;
                if (flush) begin
                    while (mq.size() > m_cmt) begin
                        void'(mq.pop_back());
                        m_tail = (m_tail + E - 1) % E;
                    end
                end else if (enq_valid && room) begin
                    if (ok) begin
                        mq.push_back(e);
                        m_tail = (m_tail + 1) % E;
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
    end

    // Count completed drain writes seen at the DUT boundary.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && mem_wr_valid && mem_wr_ready) n_drained++;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            bit          e_hit;
            bit          e_part;
            logic [31:0] e_data;
            @(negedge clk);
            chk("count",     64'(count),        64'(mq.size()));
            chk("full",      64'(full),         64'(mq.size() == E));
            chk("empty",     64'(empty),        64'(mq.size() == 0));
            chk("enq_ready", 64'(enq_ready),    64'(mq.size() != E));
            chk("wr_valid",  64'(mem_wr_valid), 64'(m_cmt > 0));
            chk("sq_id",     64'(enq_sq_id),    64'(m_tail));
            chk("enq_err",   64'(enq_err),      64'(m_err));
            if (m_cmt > 0) begin
                chk("wr_addr", 64'(mem_wr_addr), 64'(mq[0].addr));
                chk("wr_strb", 64'(mem_wr_strb), 64'(mq[0].strb));
                chk("wr_data", 64'(mem_wr_data & byte_mask(mem_wr_strb)), 64'(mq[0].data));
            end
            if (lookup_valid) begin
                model_fwd(lookup_addr, lookup_size, e_hit, e_part, e_data);
                chk("fwd_hit",     64'(fwd_hit),     64'(e_hit));
                chk("fwd_partial", 64'(fwd_partial), 64'(e_part));
                chk("fwd_data",    64'(fwd_data),    64'(e_data));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_enq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_data  = d;
        enq_size  = s;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic probe(input logic [31:0] a, input logic [1:0] s);
        lookup_valid = 1'b1;
        lookup_addr  = a;
        lookup_size  = s;
        #1;
    endtask

    task automatic drain_all();
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 40 && mem_wr_valid; i++) tick();
        chk("drain_done", 64'(mem_wr_valid), 64'(0));
        mem_wr_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;

        // Reset state.
        repeat (3) tick();
        probe(32'h1000, 2'b10);
        chk("rst_count",   64'(count),        64'(0));
        chk("rst_empty",   64'(empty),        64'(1));
        chk("rst_full",    64'(full),         64'(0));
        chk("rst_ready",   64'(enq_ready),    64'(1));
        chk("rst_wrvalid", 64'(mem_wr_valid), 64'(0));
        chk("rst_err",     64'(enq_err),      64'(0));
        chk("rst_hit",     64'(fwd_hit),      64'(0));
        chk("rst_partial", 64'(fwd_partial),  64'(0));
        lookup_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // SB 0x1003: lane 3 only.
        do_enq(32'h1003, 32'hFFFF_FFAB, 2'b00);
        chk("sb_spec_not_drained", 64'(mem_wr_valid), 64'(0));
        do_commit();
        chk("sb_wr_valid", 64'(mem_wr_valid), 64'(1));
        chk("sb_wr_addr",  64'(mem_wr_addr),  64'(32'h1000));
        chk("sb_wr_strb",  64'(mem_wr_strb),  64'(4'b1000));
        chk("sb_wr_data",  64'(mem_wr_data & 32'hFF00_0000), 64'(32'hAB00_0000));
        drain_all();

        // SW then SB into the same word; word probe merges both.
        do_enq(32'h2000, 32'h1122_3344, 2'b10);
        do_enq(32'h2001, 32'h0000_00EE, 2'b00);
        probe(32'h2000, 2'b10);
`ifdef STORE_COMMIT_QUEUE_FWD_EN
        chk("merge_hit",     64'(fwd_hit),     64'(1));
        chk("merge_partial", 64'(fwd_partial), 64'(0));
        chk("merge_data",    64'(fwd_data),    64'(32'h1122_EE44));
`else
        chk("merge_hit",     64'(fwd_hit),     64'(0));
        chk("merge_partial", 64'(fwd_partial), 64'(1));
        chk("merge_data",    64'(fwd_data),    64'(0));
`endif
        probe(32'h2004, 2'b10);
        chk("other_word_partial", 64'(fwd_partial), 64'(0));
        probe(32'h2001, 2'b00);
        tick();
        // A store enqueued this cycle is invisible to the probe.
        probe(32'h7000, 2'b10);
        enq_valid = 1'b1;
        enq_addr  = 32'h7000;
        enq_data  = 32'hCAFE_F00D;
        enq_size  = 2'b10;
        #1;
        chk("same_cycle_invisible", 64'(fwd_partial), 64'(0));
        tick();
        enq_valid = 1'b0;
        #1;
        chk("next_cycle_visible", 64'(fwd_partial | fwd_hit), 64'(1));
        lookup_valid = 1'b0;
        do_flush();
        chk("flush_all_spec", 64'(count), 64'(0));

        // SH under an LW probe is only a partial cover.
        do_enq(32'h3000, 32'h0000_5566, 2'b01);
        probe(32'h3000, 2'b10);
        chk("sh_lw_partial", 64'(fwd_partial), 64'(1));
        chk("sh_lw_hit",     64'(fwd_hit),     64'(0));
        probe(32'h3000, 2'b01);
        tick();
        lookup_valid = 1'b0;
        do_flush();

        // 3 stores, commit 1, flush: one survives and drains.
        base = n_drained;
        do_enq(32'h5000, 32'h0000_0001, 2'b10);
        do_enq(32'h5004, 32'h0000_0002, 2'b10);
        do_enq(32'h5008, 32'h0000_0003, 2'b10);
        do_commit();
        do_flush();
        chk("flush_count", 64'(count),     64'(1));
        chk("flush_tail",  64'(enq_sq_id), 64'(2));
        do_commit(); // nothing speculative: ignored
        chk("idle_commit_count", 64'(count), 64'(1));
        drain_all();
        chk("flush_drained", 64'(n_drained - base), 64'(1));

        // Same-cycle enqueue is not committable; commit+flush keeps committed one.
        enq_valid    = 1'b1;
        enq_addr     = 32'h5100;
        enq_size     = 2'b10;
        commit_valid = 1'b1;
        tick();
        enq_valid    = 1'b0;
        commit_valid = 1'b0;
        chk("enq_commit_same", 64'(mem_wr_valid), 64'(0));
        do_enq(32'h5104, 32'h0000_0004, 2'b10);
        commit_valid = 1'b1;
        flush        = 1'b1;
        tick();
        commit_valid = 1'b0;
        flush        = 1'b0;
        chk("commit_flush_count", 64'(count),        64'(1));
        chk("commit_flush_valid", 64'(mem_wr_valid), 64'(1));
        drain_all();

        // Fill to capacity with the drain stalled.
        for (int i = 0; i < E; i++) do_enq(32'h6000 + 32'(4 * i), 32'h0000_00A0 + 32'(i), 2'b10);
        chk("fill_full",  64'(full),      64'(1));
        chk("fill_ready", 64'(enq_ready), 64'(0));
        chk("fill_count", 64'(count),     64'(E));
        do_enq(32'h6100, 32'h0000_00FF, 2'b10);
        chk("full_enq_ignored", 64'(count), 64'(E));
        commit_valid = 1'b1;
        repeat (E) tick();
        commit_valid = 1'b0;
        mem_wr_ready = 1'b1;
        tick();
        chk("pop_count", 64'(count), 64'(E - 1));
        do_enq(32'h6200, 32'h0000_00BB, 2'b10);
        chk("enq_pop_count", 64'(count), 64'(E - 1));
        mem_wr_ready = 1'b0;
        do_flush();
        drain_all();
        chk("fill_drained_empty", 64'(empty), 64'(1));

        // Misaligned / illegal stores are dropped with a one-cycle pulse.
        do_enq(32'h4002, 32'h1234_5678, 2'b10);
        chk("misalign_err",   64'(enq_err), 64'(1));
        chk("misalign_count", 64'(count),   64'(0));
        tick();
        chk("err_one_cycle", 64'(enq_err), 64'(0));
        do_enq(32'h4003, 32'h0000_1234, 2'b01);
        chk("sh_cross_err", 64'(enq_err), 64'(1));
        do_enq(32'h4000, 32'h0000_0001, 2'b11);
        chk("sd_illegal_err", 64'(enq_err), 64'(1));
        do_enq(32'h4001, 32'h0000_0077, 2'b01);
        chk("sh_ok_err",   64'(enq_err), 64'(0));
        chk("sh_ok_count", 64'(count),   64'(1));
        do_flush();

        // Reset in the middle of a drain.
        do_enq(32'h8000, 32'h0000_0011, 2'b10);
        do_enq(32'h8004, 32'h0000_0022, 2'b10);
        do_commit();
        do_commit();
        chk("pre_rst_valid", 64'(mem_wr_valid), 64'(1));
        base = n_drained;
        mem_wr_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(mem_wr_valid), 64'(0));
        chk("rst_mid_count", 64'(count),        64'(0));
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_no_write", 64'(n_drained - base), 64'(0));
        mem_wr_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
